// File: rtl/dcache_controller_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
package dcache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int LINE_WORDS  = 16;
    localparam int OFFSET_BITS = 6;

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines);
        return 32 - OFFSET_BITS - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag, valid and data arrays: combinational lookup, line fill, word/byte update.
module dcache_store
    import dcache_controller_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [index_bits(LINES)-1:0]   index,
    input  logic [tag_bits(LINES)-1:0]     tag,
    input  logic [3:0]                     word,
    output logic                           hit,
    output logic [31:0]                    rdata,
    input  logic                           fill,
    input  logic [32*LINE_WORDS-1:0]       line,
    input  logic                           update,
    input  logic                           sb,
    input  logic [1:0]                     lane,
    input  logic [31:0]                    wdata
);

    logic [LINES-1:0]           valid;
    logic [tag_bits(LINES)-1:0] tags [LINES];
    logic [31:0]                data [LINES][LINE_WORDS];

    assign hit   = valid[index] && (tags[index] == tag);
    assign rdata = data[index][word];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
        end
    end

    // Contents need no reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[index] <= tag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                data[index][i] <= line[32*i +: 32];
            end
        end else if (update) begin
            if (sb) begin
                data[index][word][{lane, 3'b000} +: 8] <= wdata[7:0];
            end else begin
                data[index][word] <= wdata;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [31:0]              cpuAddress,
    input  logic [31:0]              cpuWriteData,
    input  logic                     cpuRead,
    input  logic                     cpuWrite,
    input  logic                     cpuSb,
    output logic [31:0]              cpuReadData,
    output logic                     stall,
    output logic [31:0]              memAddress,
    output logic [31:0]              memWriteData,
    output logic                     memWrite,
    output logic                     memSb,
    input  logic [32*LINE_WORDS-1:0] memLine,
    output logic [CNT_W-1:0]         hitCount,
    output logic [CNT_W-1:0]         missCount
);

    localparam int IB    = index_bits(LINES);
    localparam int TB    = tag_bits(LINES);
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    state_t            state, next;
    logic [LAT_W-1:0]  lat;
    logic              just_filled;
    logic              hit;
    logic [31:0]       word_data;
    logic              fill_en, upd_en;
    logic              hit_inc, miss_inc, lat_load;
    logic [31:0]       line_addr;

    assign line_addr    = {cpuAddress[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign memWriteData = cpuWriteData;

    dcache_store #(.LINES(LINES)) u_store (
        .clk    (clk),
        .rst_n  (resetN),
        .index  (cpuAddress[OFFSET_BITS +: IB]),
        .tag    (cpuAddress[31 -: TB]),
        .word   (cpuAddress[5:2]),
        .hit    (hit),
        .rdata  (word_data),
        .fill   (fill_en),
        .line   (memLine),
        .update (upd_en),
        .sb     (cpuSb),
        .lane   (cpuAddress[1:0]),
        .wdata  (cpuWriteData)
    );

    always_comb begin
        next        = state;
        stall       = 1'b0;
        cpuReadData = '0;
        memAddress  = '0;
        memWrite    = 1'b0;
        memSb       = 1'b0;
        fill_en     = 1'b0;
        upd_en      = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        lat_load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpuWrite) begin
                    stall = 1'b1;
                    next  = WRITE;
                end else if (cpuRead && hit) begin
                    cpuReadData = word_data;
                    hit_inc     = !just_filled;
                end else if (cpuRead) begin
                    stall      = 1'b1;
                    memAddress = line_addr;
                    miss_inc   = 1'b1;
                    lat_load   = 1'b1;
                    next       = FILL;
                end
            end
            FILL: begin
                stall      = 1'b1;
                memAddress = line_addr;
                if (lat == '0) begin
                    fill_en = 1'b1;
                    next    = IDLE;
                end
            end
            WRITE: begin
                memWrite   = 1'b1;
                memAddress = cpuAddress;
                memSb      = cpuSb;
                upd_en     = hit;
                next       = IDLE;
            end
            default: next = IDLE;
        endcase
        // Reset aborts any fill or store strobe in flight.
        if (!resetN) begin
            next        = IDLE;
            stall       = 1'b0;
            cpuReadData = '0;
            memAddress  = '0;
            memWrite    = 1'b0;
            memSb       = 1'b0;
            fill_en     = 1'b0;
            upd_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            lat         <= '0;
            just_filled <= 1'b0;
            hitCount    <= '0;
            missCount   <= '0;
        end else begin
            state <= next;
            if (lat_load) begin
                lat <= LAT_W'(MEM_LATENCY - 1);
            end else if (state == FILL && lat != '0) begin
                lat <= lat - 1'b1;
            end
            if (fill_en) begin
                just_filled <= 1'b1;
            end else if (state == IDLE) begin
                just_filled <= 1'b0;
            end
            if (hit_inc && hitCount != '1) begin
                hitCount <= hitCount + 1'b1;
            end
            if (miss_inc && missCount != '1) begin
                missCount <= missCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a simple word-addressed memory model.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         resetN;
    logic [31:0]  cpuAddress;
    logic [31:0]  cpuWriteData;
    logic         cpuRead;
    logic         cpuWrite;
    logic         cpuSb;
    logic [31:0]  cpuReadData;
    logic         stall;
    logic [31:0]  memAddress;
    logic [31:0]  memWriteData;
    logic         memWrite;
    logic         memSb;
    logic [511:0] memLine;
    logic [15:0]  hitCount;
    logic [15:0]  missCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    dcache_controller #(
        .LINES(16), .MEM_LATENCY(4), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .cpuAddress   (cpuAddress),
        .cpuWriteData (cpuWriteData),
        .cpuRead      (cpuRead),
        .cpuWrite     (cpuWrite),
        .cpuSb        (cpuSb),
        .cpuReadData  (cpuReadData),
        .stall        (stall),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memSb        (memSb),
        .memLine      (memLine),
        .hitCount     (hitCount),
        .missCount    (missCount)
    );

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            memLine[32*k +: 32] = mem[{memAddress[11:6], 4'(k)}];
        end
    end

    // Memory contents and write-through updates, owned by one process.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA500_0000 | i;
        end
        mem[0] = 32'h0000_0001;
        mem[1] = 32'hF000_F002;
        forever begin
            @(negedge clk);
            #2;
            if (memWrite === 1'b1) begin
                if (memSb) begin
                    mem[memAddress[11:2]][{memAddress[1:0], 3'b000} +: 8] = memWriteData[7:0];
                end else begin
                    mem[memAddress[11:2]] = memWriteData;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr,
                           input int exp_stalls, input logic [31:0] exp_data);
        int n;
        n = 0;
        @(negedge clk);
        cpuRead    = 1'b1;
        cpuWrite   = 1'b0;
        cpuSb      = 1'b0;
        cpuAddress = addr;
        #1;
        if (exp_stalls > 0) begin
            chk({tag, " line_addr"}, memAddress, {addr[31:6], 6'b0});
        end
        while (stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, " stalls"}, n, exp_stalls);
        chk({tag, " data"}, cpuReadData, exp_data);
    endtask

    initial begin
        resetN       = 1'b0;
        cpuRead      = 1'b0;
        cpuWrite     = 1'b0;
        cpuSb        = 1'b0;
        cpuAddress   = '0;
        cpuWriteData = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst stall", stall, 0);
        chk("rst memWrite", memWrite, 0);
        chk("rst memSb", memSb, 0);
        chk("rst memAddress", memAddress, 0);
        chk("rst hitCount", hitCount, 0);
        chk("rst missCount", missCount, 0);
        @(negedge clk);
        resetN = 1'b1;

        // Cold miss then zero-wait hits
        do_load("t1", 32'h4, 5, 32'hF000_F002);
        chk("t1 missCount", missCount, 1);
        chk("t1 hitCount", hitCount, 0);
        do_load("t2", 32'h0, 0, 32'h0000_0001);
        @(negedge clk);
        cpuRead = 1'b0;
        #1;
        chk("t2 hitCount", hitCount, 1);
        chk("t2 missCount", missCount, 1);

        // Word store hitting the cached line
        @(negedge clk);
        cpuWrite     = 1'b1;
        cpuAddress   = 32'h8;
        cpuWriteData = 32'hDEAD_BEEF;
        #1;
        chk("t3 stall", stall, 1);
        chk("t3 early memWrite", memWrite, 0);
        @(negedge clk);
        #1;
        chk("t3 memWrite", memWrite, 1);
        chk("t3 memAddress", memAddress, 32'h8);
        chk("t3 memSb", memSb, 0);
        chk("t3 strobe stall", stall, 0);
        do_load("t3", 32'h8, 0, 32'hDEAD_BEEF);
        chk("t3 single strobe", memWrite, 0);

        // Byte store into lane 2
        @(negedge clk);
        cpuRead      = 1'b0;
        cpuWrite     = 1'b1;
        cpuSb        = 1'b1;
        cpuAddress   = 32'hA;
        cpuWriteData = 32'h0000_00AB;
        #1;
        chk("t4 stall", stall, 1);
        @(negedge clk);
        #1;
        chk("t4 memWrite", memWrite, 1);
        chk("t4 memSb", memSb, 1);
        chk("t4 memAddress", memAddress, 32'hA);
        do_load("t4", 32'h8, 0, 32'hDEAB_BEEF);
        chk("t4 missCount", missCount, 1);

        // Aliasing on index 0
        do_load("t5a", 32'h0, 0, 32'h0000_0001);
        do_load("t5b", 32'h400, 5, 32'hA500_0100);
        do_load("t5c", 32'h0, 5, 32'h0000_0001);
        @(negedge clk);
        cpuRead = 1'b0;
        #1;
        chk("t5 missCount", missCount, 3);
        chk("t5 hitCount", hitCount, 4);

        // Reset in the third FILL cycle aborts the fill
        @(negedge clk);
        cpuRead    = 1'b1;
        cpuAddress = 32'h800;
        #1;
        chk("t6 miss stall", stall, 1);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("t6 rst stall", stall, 0);
        chk("t6 rst memAddress", memAddress, 0);
        @(negedge clk);
        resetN  = 1'b1;
        cpuRead = 1'b0;
        #1;
        chk("t6 idle stall", stall, 0);
        chk("t6 missCount", missCount, 0);
        chk("t6 hitCount", hitCount, 0);

        // Read and write together: store wins
        @(negedge clk);
        cpuRead      = 1'b1;
        cpuWrite     = 1'b1;
        cpuSb        = 1'b0;
        cpuAddress   = 32'h800;
        cpuWriteData = 32'h1234_5678;
        #1;
        chk("t6 rw stall", stall, 1);
        chk("t6 rw early memWrite", memWrite, 0);
        @(negedge clk);
        #1;
        chk("t6 rw memWrite", memWrite, 1);
        chk("t6 rw memAddress", memAddress, 32'h800);
        chk("t6 rw stall2", stall, 0);
        @(negedge clk);
        cpuRead  = 1'b0;
        cpuWrite = 1'b0;
        #1;
        chk("t6 rw single strobe", memWrite, 0);
        chk("t6 rw no fill", missCount, 0);
        do_load("t6 reload", 32'h800, 5, 32'h1234_5678);
        @(negedge clk);
        cpuRead = 1'b0;
        #1;
        chk("t6 reload missCount", missCount, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the pipeline MEM stage and the data memory. The data memory presents a 16-word line combinationally from a block address and accepts single-word or single-byte writes. The controller holds tags, valid bits and line data, and stalls the pipeline on read misses and on stores. It also exports hit and miss counters.

Parameters:
LINES, 16, number of cache lines; power of 2, minimum 2.
MEM_LATENCY, 4, cycles the memLine bus must be held before it is captured; minimum 1.
CNT_W, 16, width of the hit and miss counters.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
resetN  in  1  synchronous, active-low reset.
cpuAddress  in  32  byte address from the MEM stage.
cpuWriteData  in  32  store data.
cpuRead  in  1  load request (word load; bits [1:0] ignored).
cpuWrite  in  1  store request.
cpuSb  in  1  the store is a byte store (sb); bits [1:0] select the byte lane.
cpuReadData  out  32  load result; valid when cpuRead=1 and stall=0.
stall  out  1  pipeline freeze; the CPU holds all cpu* inputs stable while this is 1.
memAddress  out  32  to data memory; line-aligned during FILL, cpuAddress during WRITE.
memWriteData  out  32  equals cpuWriteData.
memWrite  out  1  one-cycle store strobe to data memory.
memSb  out  1  byte-store qualifier to data memory.
memLine  in  512  line from data memory; word i is at bits [32i+31:32i].
hitCount  out  CNT_W  saturating count of read hits.
missCount  out  CNT_W  saturating count of read misses.

Behaviour:
- Address split: offset = [5:0]; word = [5:2]; index = [5+log2(LINES):6]; tag = the remaining upper bits.
- A lookup hits when valid[index]=1 and tagArr[index]=tag.
- FSM states are IDLE, FILL and WRITE.
- Reset (resetN=0 at a clock edge):
  - state=IDLE; all valid bits=0; latency counter=0; counters=0; justFilled=0.
  - stall, memWrite and memSb are 0; memAddress=0.
  - Data and tag arrays need no reset.
- Reset asserted during FILL or WRITE: the operation is aborted and the line is left invalid. No memWrite is issued in the reset cycle.
- IDLE, cpuWrite=1 (takes priority over cpuRead if both are 1):
  - stall=1; next state WRITE.
- IDLE, cpuRead=1, hit:
  - stall=0; cpuReadData = data[index][word], combinational and zero-wait.
  - hitCount increments unless justFilled=1.
- IDLE, cpuRead=1, miss:
  - stall=1; memAddress = {cpuAddress[31:6], 6'b0}; missCount increments.
  - Latency counter loads MEM_LATENCY-1; next state FILL.
- IDLE, no request: stall=0; cpuReadData=0; no counter change.
- FILL:
  - stall=1; memAddress is held line-aligned; the counter decrements each cycle.
  - On the cycle the counter is 0:
    - Capture all of memLine into data[index]; write tagArr[index]; set valid[index]=1; set justFilled=1.
    - Return to IDLE.
  - The next IDLE cycle hits with stall=0.
  - Total stall for a read miss is MEM_LATENCY+1 cycles.
- WRITE:
  - memWrite=1 for exactly one cycle, with memAddress=cpuAddress and memSb=cpuSb; stall=0; next state IDLE.
  - If the address hits, the cached copy is updated in the same cycle:
    - cpuSb=0: the whole word is replaced.
    - cpuSb=1: only byte lane [1:0] of the word is replaced, with cpuWriteData[7:0].
  - A store miss does not allocate and leaves tags and valid bits unchanged.
- Store latency: 2 cycles (one stall cycle, then the strobe cycle).
- justFilled clears on any IDLE cycle that is not the first cycle after FILL.
- Counters hold at all-ones; they never wrap.
- Aliasing: two addresses with the same index and different tags evict each other. The last fill wins.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE, FILL, WRITE).
  - LINE_WORDS=16 and OFFSET_BITS=6.
  - Localparam functions for INDEX_BITS and TAG_BITS derived from LINES.
- One natural sub-module, dcache_store: tag, valid and data arrays with:
  - a lookup port (index, tag → hit, word data);
  - a line-fill port;
  - a word/byte update port.
- The controller keeps the FSM, the latency counter and the statistics counters.

Test Plan:
1. Reset, then load 0x00000004 with memory word1=0xF000F002:
   - stall=1 for 5 cycles; then cpuReadData=0xF000F002 with stall=0.
   - missCount=1, hitCount=0.
2. Immediately reload 0x00000000 (memory word0=0x00000001):
   - same cycle cpuReadData=0x00000001, stall=0; hitCount=1.
3. Store 0xDEADBEEF to 0x8 (line cached):
   - stall 1 cycle; then memWrite=1 for one cycle with memAddress=0x8.
   - A subsequent load of 0x8 hits and returns 0xDEADBEEF.
4. Byte store 0xAB to 0xA over the cached word 0xDEADBEEF:
   - memSb=1; a later load of 0x8 returns 0xDEABBEEF with no miss.
5. Load 0x0, then load 0x400 (same index, LINES=16), then load 0x0 again:
   - three misses (missCount=3); the final data equals memory word0.
6. Assert resetN=0 on the third FILL cycle:
   - next cycle stall=0 and state=IDLE; a reload of the same address misses again.
   - Hold cpuRead and cpuWrite together: WRITE is taken, memWrite pulses once, no fill occurs.
